caesar_cipher: RTL and testbench

CAESAR_CIPHER -- requirements
Module: caesar_cipher

---
 rtl/caesar_cipher.sv | 85 ++++++++
 tb/tb_caesar_cipher.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/caesar_cipher.sv
// Caesar cipher, one character per clock, one clock of latency.
// Letters are rotated within their own case by key_shift_num positions.
// Non-letters or an out-of-range shift amount give NUL plus an error flag.
module caesar_cipher #(
   parameter int DATA_W  = 8,
   parameter int SHIFT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_shift_dir,
   input  logic [SHIFT_W-1:0] key_shift_num,
   input  logic [DATA_W-1:0]  ptxt_char,
   output logic [DATA_W-1:0]  ctxt_char,
   output logic               err_invalid_key_shift_num,
   output logic               err_invalid_ptxt_char
);

   localparam int ALPHA = 26;
   // Two extra bits: one for headroom above 'z'+26, one for the sign when shifting left.
   localparam int SUM_W = DATA_W + 2;

   localparam logic [DATA_W-1:0] UC_LO = DATA_W'('h41);
   localparam logic [DATA_W-1:0] UC_HI = DATA_W'('h5A);
   localparam logic [DATA_W-1:0] LC_LO = DATA_W'('h61);
   localparam logic [DATA_W-1:0] LC_HI = DATA_W'('h7A);

   localparam logic signed [SUM_W-1:0] ALPHA_S = SUM_W'(ALPHA);

   function automatic logic is_upper(input logic [DATA_W-1:0] ch);
      return (ch >= UC_LO) && (ch <= UC_HI);
   endfunction

   function automatic logic is_lower(input logic [DATA_W-1:0] ch);
      return (ch >= LC_LO) && (ch <= LC_HI);
   endfunction

   // Rotate a letter known to be valid; a single +/-26 correction suffices
   // because the shift amount never exceeds 26 when this result is used.
   function automatic logic [DATA_W-1:0] shift_letter(
      input logic [DATA_W-1:0]  ch,
      input logic               dir,
      input logic [SHIFT_W-1:0] num
   );
      logic signed [SUM_W-1:0] sum;
      logic signed [SUM_W-1:0] lo;
      logic signed [SUM_W-1:0] n_ext;
      n_ext = $signed({{(SUM_W-SHIFT_W){1'b0}}, num});
      lo    = is_upper(ch) ? $signed(SUM_W'(UC_LO)) : $signed(SUM_W'(LC_LO));
      sum   = $signed({2'b00, ch});
      if (dir) sum = sum - n_ext;
      else     sum = sum + n_ext;
      if (sum >= lo + ALPHA_S)  sum = sum - ALPHA_S;
      else if (sum < lo)        sum = sum + ALPHA_S;
      return sum[DATA_W-1:0];
   endfunction

   logic               key_bad_p0;
   logic               char_bad_p0;
   logic [DATA_W-1:0]  ctxt_p0;

   // ---- stage p0: classify the inputs and compute the rotated character ----
   // Classify the sampled character/key and select the cipher result or NUL.
   always_comb begin
      key_bad_p0  = key_shift_num > SHIFT_W'(ALPHA);
      char_bad_p0 = !(is_upper(ptxt_char) || is_lower(ptxt_char));
      ctxt_p0     = '0;
      if (!key_bad_p0 && !char_bad_p0)
         ctxt_p0 = shift_letter(ptxt_char, key_shift_dir, key_shift_num);
   end

   // ---- stage p1: registered outputs ----
   // Capture one result per edge; reset clears any in-flight result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctxt_char                 <= '0;
         err_invalid_key_shift_num <= 1'b0;
         err_invalid_ptxt_char     <= 1'b0;
      end else begin
         ctxt_char                 <= ctxt_p0;
         err_invalid_key_shift_num <= key_bad_p0;
         err_invalid_ptxt_char     <= char_bad_p0;
      end
   end

endmodule

// File: tb/tb_caesar_cipher.sv
// Scoreboard bench for caesar_cipher: the driver pushes the expected result of
// every character it issues, the monitor pops and compares one clock later.
module tb_caesar_cipher;

   typedef struct packed {
      logic [7:0] c;
      logic       ek;
      logic       ec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_shift_dir = 1'b0;
   logic [4:0] key_shift_num = '0;
   logic [7:0] ptxt_char = '0;
   logic [7:0] ctxt_char;
   logic       err_invalid_key_shift_num;
   logic       err_invalid_ptxt_char;

   logic       in_vld = 1'b0;
   logic       cap;
   exp_t       q[$];
   int         total = 0;
   int         bad = 0;

   caesar_cipher dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .key_shift_dir             (key_shift_dir),
      .key_shift_num             (key_shift_num),
      .ptxt_char                 (ptxt_char),
      .ctxt_char                 (ctxt_char),
      .err_invalid_key_shift_num (err_invalid_key_shift_num),
      .err_invalid_ptxt_char     (err_invalid_ptxt_char)
   );

   always #5 clk = ~clk;

   // Reference: position within the alphabet, rotated modulo 26.
   function automatic exp_t ref_model(input bit dir, input int n, input int ch);
      exp_t e;
      int   base;
      bit   letter;
      letter = 1'b0;
      base   = 0;
      if (ch >= 65 && ch <= 90) begin letter = 1'b1; base = 65; end
      if (ch >= 97 && ch <= 122) begin letter = 1'b1; base = 97; end
      e.ek = (n > 26);
      e.ec = !letter;
      if (e.ek || e.ec) e.c = 8'h00;
      else e.c = 8'(base + ((ch - base + (dir ? 26 - n : n)) % 26));
      return e;
   endfunction

   task automatic send_exp(input bit dir, input int n, input int ch, input exp_t e);
      @(negedge clk);
      key_shift_dir = dir;
      key_shift_num = 5'(n);
      ptxt_char     = 8'(ch);
      in_vld        = 1'b1;
      q.push_back(e);
   endtask

   task automatic send(input bit dir, input int n, input int ch);
      send_exp(dir, n, ch, ref_model(dir, n, ch));
   endtask

   task automatic check_zero(input string name);
      total++;
      if ({ctxt_char, err_invalid_key_shift_num, err_invalid_ptxt_char} !== 10'd0) begin
         bad++;
         $display("FAIL %s got ctxt=%h ek=%b ec=%b want all zero", name,
                  ctxt_char, err_invalid_key_shift_num, err_invalid_ptxt_char);
      end
   endtask

   task automatic check_drained(input string name);
      @(negedge clk);
      in_vld = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s outstanding=%0d want 0", name, q.size());
      end
   endtask

   // Monitor: every captured character produces one output one clock later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cap = in_vld && rst_n;
         #1;
         if (cap) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_out got ctxt=%h ek=%b ec=%b want none",
                        ctxt_char, err_invalid_key_shift_num, err_invalid_ptxt_char);
            end else begin
               e = q.pop_front();
               if ({ctxt_char, err_invalid_key_shift_num, err_invalid_ptxt_char} !== e) begin
                  bad++;
                  $display("FAIL cipher_out got ctxt=%h ek=%b ec=%b want ctxt=%h ek=%b ec=%b",
                           ctxt_char, err_invalid_key_shift_num, err_invalid_ptxt_char,
                           e.c, e.ek, e.ec);
               end
            end
         end
      end
   end

   initial begin
      string text;
      byte   enc[$];
      exp_t  e;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_init");
      @(negedge clk);
      rst_n = 1'b1;

      // Forward and backward by one over both alphabets
      for (int d = 0; d < 2; d++) begin
         for (int c = 65; c <= 90; c++)  send(d[0], 1, c);
         for (int c = 97; c <= 122; c++) send(d[0], 1, c);
      end

      // Directed N=5 examples: 'W' right -> 'B', 'c' left -> 'x'
      e = '{c: 8'h42, ek: 1'b0, ec: 1'b0};
      send_exp(1'b0, 5, 8'h57, e);
      e = '{c: 8'h78, ek: 1'b0, ec: 1'b0};
      send_exp(1'b1, 5, 8'h63, e);
      // 'Z'+1 -> 'A', 'a'-1 -> 'z'
      e = '{c: 8'h41, ek: 1'b0, ec: 1'b0};
      send_exp(1'b0, 1, 8'h5A, e);
      e = '{c: 8'h7A, ek: 1'b0, ec: 1'b0};
      send_exp(1'b1, 1, 8'h61, e);

      // Full character sweep, including the class boundaries and 0x80..0xFF
      for (int c = 0; c < 256; c++) send(1'b0, 5, c);

      // Shift amount boundaries on every letter
      for (int c = 0; c < 256; c++) begin
         if ((c >= 65 && c <= 90) || (c >= 97 && c <= 122)) begin
            send(1'b0, 27, c);
            send(1'b1, 26, c);
            send(1'b0, 26, c);
            send(1'b1, 0, c);
            send(1'b0, 31, c);
         end
      end

      // Round trip: encrypt, then decrypt the letters back to the original
      text = "Hello World, Zebra xyz ABC!";
      for (int i = 0; i < text.len(); i++) begin
         send(1'b0, 2, text[i]);
         e = ref_model(1'b0, 2, text[i]);
         enc.push_back(e.c);
      end
      for (int i = 0; i < text.len(); i++) begin
         if (!e.ec || 1'b1) begin
            if (enc[i] != 8'h00) begin
               e = '{c: text[i], ek: 1'b0, ec: 1'b0};
               send_exp(1'b1, 2, enc[i], e);
            end
         end
      end

      // Random characters with the key changing every cycle
      for (int i = 0; i < 400; i++)
         send($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 255));

      check_drained("drain_main");

      // Asynchronous reset in the middle of a stream
      send(1'b0, 3, 8'h4B);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("reset_async");
      ptxt_char = 8'h51;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      key_shift_dir = 1'b0;
      key_shift_num = 5'd4;
      ptxt_char     = 8'h62;
      q.push_back(ref_model(1'b0, 4, 8'h62));
      #1;
      check_zero("reset_no_stale");
      send(1'b1, 7, 8'h7A);
      send(1'b0, 0, 8'h40);
      check_drained("drain_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
